ram_stream_fifo: RTL and testbench

RAM_STREAM_FIFO -- requirements
Module: ram_stream_fifo

---
 rtl/ram_stream_fifo.sv | 145 ++++++++++++++
 tb/tb_ram_stream_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_fifo.sv
// First-word-fall-through stream FIFO on a simple dual-port RAM with a
// LATENCY-cycle read path; a small skid buffer behind the read pipe keeps throughput at one word per cycle.
module ram_stream_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int LATENCY    = 1,
  parameter int AF_THRESH  = (2 ** DEPTH_LOG2) - 2,
  parameter int AE_THRESH  = 1,
  parameter     RAMSTYLE   = ""
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clken,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int SKID  = LATENCY + 1;
  localparam int SW    = $clog2(SKID);
  localparam int SCW   = $clog2(SKID + 1);

  (* ramstyle = RAMSTYLE, ram_style = RAMSTYLE *)
  logic [WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg, count_next, ram_count_reg, outstanding;
  logic                  alive_reg, af_reg, ae_reg;
  logic [LATENCY-1:0]    pipe_valid_reg;
  logic [WIDTH-1:0]      pipe_data_reg [LATENCY];
  logic [WIDTH-1:0]      skid_mem [SKID];
  logic [SW-1:0]         skid_head_reg, skid_tail_reg;
  logic [SCW-1:0]        skid_count_reg;
  logic                  skid_nonempty, tail_valid;
  logic                  push, pop, issue, skid_push, skid_pop;

  function automatic logic [SW-1:0] skid_inc(input logic [SW-1:0] idx);
    return (idx == SW'(SKID - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign skid_nonempty = (skid_count_reg != '0);
  assign tail_valid    = pipe_valid_reg[LATENCY-1];

  assign in_ready     = clken & alive_reg & (count_reg < CW'(DEPTH));
  assign out_valid    = clken & (skid_nonempty | tail_valid);
  assign out_data     = skid_nonempty ? skid_mem[skid_head_reg] : pipe_data_reg[LATENCY-1];
  assign count        = count_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Words already read out of the RAM (in the read pipe or skid buffer) are
  // capped at LATENCY+1 so the skid buffer can never overflow.
  assign outstanding = count_reg - ram_count_reg;
  assign issue = clken & ~flush & (ram_count_reg != '0) &
                 (outstanding <= CW'(LATENCY) + CW'(pop));

  // The pipe tail is consumed directly only when the skid buffer is empty.
  assign skid_pop  = pop & skid_nonempty;
  assign skid_push = clken & ~flush & tail_valid & ~(pop & ~skid_nonempty);

  always_comb begin
    count_next = count_reg;
    if (flush)
      count_next = '0;
    else if (push & ~pop)
      count_next = count_reg + 1'b1;
    else if (pop & ~push)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      alive_reg      <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      ram_count_reg  <= '0;
      af_reg         <= 1'b0;
      ae_reg         <= 1'b1;
      pipe_valid_reg <= '0;
      skid_head_reg  <= '0;
      skid_tail_reg  <= '0;
      skid_count_reg <= '0;
    end else begin
      alive_reg <= 1'b1;
      if (clken) begin
        count_reg <= count_next;
        af_reg    <= (int'(count_next) >= AF_THRESH);
        ae_reg    <= (int'(count_next) <= AE_THRESH);
        if (flush) begin
          wr_ptr_reg     <= '0;
          rd_ptr_reg     <= '0;
          ram_count_reg  <= '0;
          pipe_valid_reg <= '0;
          skid_head_reg  <= '0;
          skid_tail_reg  <= '0;
          skid_count_reg <= '0;
        end else begin
          if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (issue)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          ram_count_reg <= ram_count_reg + CW'(push) - CW'(issue);
          for (int i = LATENCY - 1; i > 0; i--)
            pipe_valid_reg[i] <= pipe_valid_reg[i-1];
          pipe_valid_reg[0] <= issue;
          if (skid_pop)
            skid_head_reg <= skid_inc(skid_head_reg);
          if (skid_push)
            skid_tail_reg <= skid_inc(skid_tail_reg);
          skid_count_reg <= skid_count_reg + SCW'(skid_push) - SCW'(skid_pop);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= in_data;
  end

  // Registered RAM read followed by the remaining read-latency stages.
  always_ff @(posedge clk) begin
    if (clken) begin
      pipe_data_reg[0] <= mem[rd_ptr_reg];
      for (int i = 1; i < LATENCY; i++)
        pipe_data_reg[i] <= pipe_data_reg[i-1];
      if (skid_push)
        skid_mem[skid_tail_reg] <= pipe_data_reg[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_ram_stream_fifo.sv
// Directed bench for ram_stream_fifo: default instance checked against a
// reference queue, plus LATENCY=2/3 instances for first-word latency.
module tb_ram_stream_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, clken, flush, in_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic        in_ready, out_valid, af, ae;
  logic [4:0]  count;

  logic        lv, lr;
  logic [7:0]  ld, out_data2, out_data3;
  logic        in_ready2, out_valid2, af2, ae2, in_ready3, out_valid3, af3, ae3;
  logic [4:0]  count2, count3;

  ram_stream_fifo u0 (
    .clk(clk), .resetn(resetn), .clken(clken), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(af), .almost_empty(ae)
  );

  ram_stream_fifo #(.WIDTH(8), .LATENCY(2)) u2 (
    .clk(clk), .resetn(resetn), .clken(clken), .flush(flush),
    .in_valid(lv), .in_ready(in_ready2), .in_data(ld),
    .out_valid(out_valid2), .out_ready(lr), .out_data(out_data2),
    .count(count2), .almost_full(af2), .almost_empty(ae2)
  );

  ram_stream_fifo #(.WIDTH(8), .LATENCY(3)) u3 (
    .clk(clk), .resetn(resetn), .clken(clken), .flush(flush),
    .in_valid(lv), .in_ready(in_ready3), .in_data(ld),
    .out_valid(out_valid3), .out_ready(lr), .out_data(out_data3),
    .count(count3), .almost_full(af3), .almost_empty(ae3)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One clock of stream traffic, checked against the reference queue.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy);
    logic push, pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, (clken && q.size() < 16));
    push = iv & in_ready;
    pop  = out_valid & ordy;
    if (out_valid) begin
      if (q.size() == 0)
        chk("spurious_out_valid", out_valid, 1'b0);
      else
        chk("out_data", out_data, q[0]);
    end
    step;
    if (pop && q.size() > 0) begin
      $display("pop  data=0x%08h count=%0d", q[0], count);
      void'(q.pop_front());
    end
    if (push)
      q.push_back(d);
    chk("count", count, q.size());
    chk("almost_full", af, (q.size() >= 14));
    chk("almost_empty", ae, (q.size() <= 1));
  endtask

  task automatic drain;
    for (int g = 0; g < 60 && q.size() > 0; g++)
      cycle(1'b0, 32'h0, 1'b1);
    chk("drain_done", q.size(), 0);
    chk("drain_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; clken = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    lv = 1'b0; ld = '0; lr = 1'b0;
    step; step;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_almost_full", af, 1'b0);
    chk("rst_almost_empty", ae, 1'b1);
    chk("rst_out_valid_l3", out_valid3, 1'b0);
    resetn = 1'b1;
    step;
    chk("in_ready_after_reset", in_ready, 1'b1);

    // First-word latency for LATENCY=1,2,3.
    in_valid = 1'b1; in_data = 32'h5A; lv = 1'b1; ld = 8'h5A;
    step;
    in_valid = 1'b0; lv = 1'b0;
    q.push_back(32'h5A);
    for (int k = 1; k <= 4; k++) begin
      chk("lat1_out_valid", out_valid, (k >= 2));
      chk("lat2_out_valid", out_valid2, (k >= 3));
      chk("lat3_out_valid", out_valid3, (k >= 4));
      step;
    end
    chk("lat2_data", out_data2, 8'h5A);
    chk("lat3_data", out_data3, 8'h5A);
    cycle(1'b0, 32'h0, 1'b1);

    // Fill to capacity; the 17th offer must be refused.
    for (int i = 1; i <= 16; i++)
      cycle(1'b1, 32'(i), 1'b0);
    cycle(1'b1, 32'h11, 1'b0);
    chk("full_head", out_data, 32'h1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_full_rate", out_valid, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
    end
    chk("empty_after_full", count, 0);

    // Sustained push and pop across several pointer wraps.
    for (int i = 0; i < 100; i++) begin
      if (i >= 2)
        chk("stream_out_valid", out_valid, 1'b1);
      cycle(1'b1, 32'h1000 + 32'(i), 1'b1);
    end
    drain;

    // Random backpressure on both sides.
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) != 0));
    drain;

    // Clock enable low mid-stream freezes everything.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h2000 + 32'(i), 1'b0);
    clken = 1'b0; in_valid = 1'b1; in_data = 32'hBEEF; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("clken_in_ready", in_ready, 1'b0);
      chk("clken_out_valid", out_valid, 1'b0);
      step;
      chk("clken_count", count, 4);
    end
    clken = 1'b1;
    drain;

    // Flush with nine words held and reads in flight.
    for (int i = 0; i < 9; i++)
      cycle(1'b1, 32'hA0 + 32'(i), 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1;
    step;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q.delete();
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_almost_empty", ae, 1'b1);
    cycle(1'b1, 32'hB1, 1'b0);
    drain;

    // Reset pulse with five words held.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'hC0 + 32'(i), 1'b0);
    resetn = 1'b0; in_valid = 1'b1; in_data = 32'hBAD;
    step;
    in_valid = 1'b0;
    q.delete();
    chk("midrst_count", count, 0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_almost_empty", ae, 1'b1);
    chk("midrst_almost_full", af, 1'b0);
    resetn = 1'b1;
    step;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);
    cycle(1'b1, 32'hD1, 1'b0);
    drain;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
